// File: rtl/block_spawner_if.sv
// Spawner-side bundle: level control, pattern ROM port and mover slot signals.
interface block_spawner_if #(
    parameter int NUM_BLOCKS = 4,
    parameter int ADDR_W     = 8
);
    logic                       level_start;
    logic [15:0]                pattern_data;
    logic [ADDR_W-1:0]          pattern_addr;
    logic [NUM_BLOCKS-1:0]      slot_end_level;
    logic [NUM_BLOCKS-1:0]      slot_hit;
    logic [NUM_BLOCKS-1:0]      block_ready;
    logic [NUM_BLOCKS-1:0]      slot_clear;
    logic [10*NUM_BLOCKS-1:0]   block_x_center;
    logic                       level_done;
    logic [7:0]                 spawn_count;

    modport master (
        input  level_start, pattern_data, slot_end_level, slot_hit,
        output pattern_addr, block_ready, slot_clear, block_x_center,
        output level_done, spawn_count
    );

    modport slave (
        output level_start, pattern_data, slot_end_level, slot_hit,
        input  pattern_addr, block_ready, slot_clear, block_x_center,
        input  level_done, spawn_count
    );
endinterface

// File: rtl/block_spawner.sv
// Level sequencer: walks the spawn pattern ROM, waits the frame gap,
// claims the lowest free mover slot and tracks slot release / level end.
module block_spawner #(
    parameter int         NUM_BLOCKS = 4,
    parameter int         ADDR_W     = 8,
    parameter logic [9:0] LANE0_X    = 10'd160,
    parameter logic [9:0] LANE1_X    = 10'd280,
    parameter logic [9:0] LANE2_X    = 10'd400,
    parameter logic [9:0] LANE3_X    = 10'd520
) (
    input logic             frame_clk,
    input logic             Reset,
    block_spawner_if.master bus
);
    localparam int SW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] PLACE  = 3'd4;
    localparam logic [2:0] ARM    = 3'd5;
    localparam logic [2:0] DRAIN  = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    logic [2:0]              state;
    logic [ADDR_W-1:0]       addr;
    logic [NUM_BLOCKS-1:0]   busy;
    logic [NUM_BLOCKS-1:0]   ready;
    logic [NUM_BLOCKS-1:0]   clear;
    logic [10*NUM_BLOCKS-1:0] xc;
    logic                    done;
    logic [7:0]              count;
    logic [7:0]              delay_cnt;
    logic [1:0]              lane;
    logic [SW-1:0]           slot;

    logic                    free_any;
    logic [SW-1:0]           free_idx;
    logic [NUM_BLOCKS-1:0]   rel;
    logic                    unused_bits;

    assign unused_bits = ^bus.pattern_data[12:8];

    function automatic logic [9:0] lane_x(input logic [1:0] l);
        case (l)
            2'd0:    return LANE0_X;
            2'd1:    return LANE1_X;
            2'd2:    return LANE2_X;
            default: return LANE3_X;
        endcase
    endfunction

    // Lowest-index idle slot, judged on the registered busy vector.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    // Ready gating keeps a stale end_level during the clear frame harmless.
    assign rel = busy & ready & (bus.slot_end_level | bus.slot_hit);

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            addr      <= '0;
            busy      <= '0;
            ready     <= '0;
            clear     <= '0;
            xc        <= {NUM_BLOCKS{LANE0_X}};
            done      <= 1'b0;
            count     <= 8'd0;
            delay_cnt <= 8'd0;
            lane      <= 2'd0;
            slot      <= '0;
        end else begin
            busy  <= busy & ~rel;
            ready <= ready & ~rel;
            case (state)
                IDLE, DONE: begin
                    if (bus.level_start) begin
                        addr  <= '0;
                        count <= 8'd0;
                        done  <= 1'b0;
                        state <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (bus.pattern_data[15]) begin
                        state <= DRAIN;
                    end else begin
                        lane      <= bus.pattern_data[14:13];
                        delay_cnt <= bus.pattern_data[7:0];
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (delay_cnt == 8'd0) state <= PLACE;
                    else delay_cnt <= delay_cnt - 8'd1;
                end
                PLACE: begin
                    if (free_any) begin
                        slot                          <= free_idx;
                        xc[10*int'(free_idx) +: 10]   <= lane_x(lane);
                        clear[free_idx]               <= 1'b1;
                        busy[free_idx]                <= 1'b1;
                        state                         <= ARM;
                    end
                end
                ARM: begin
                    clear       <= '0;
                    ready[slot] <= 1'b1;
                    if (count != 8'hFF) count <= count + 8'd1;
                    if (&addr) begin
                        state <= DRAIN;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (busy == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pattern_addr   = addr;
    assign bus.block_ready    = ready;
    assign bus.slot_clear     = clear;
    assign bus.block_x_center = xc;
    assign bus.level_done     = done;
    assign bus.spawn_count    = count;
endmodule

// File: tb/tb_block_spawner.sv
// Scoreboard bench for block_spawner: spawn records queued with the ROM
// program, popped on every slot_clear pulse; ADDR_W=2 copy for address end.
module tb_block_spawner;
    typedef struct {
        logic [3:0] mask;
        logic [9:0] x;
    } spawn_t;

    localparam logic [39:0] X_RST = {4{10'd160}};
    localparam logic [15:0] ENDE  = 16'h8000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   t0 = 0;

    logic [15:0] rom1 [0:255];
    logic [15:0] rom2 [0:3];
    spawn_t      sb [$];
    logic [3:0]  prev_clear = 4'd0;

    block_spawner_if #(.NUM_BLOCKS(4), .ADDR_W(8)) b1 ();
    block_spawner_if #(.NUM_BLOCKS(4), .ADDR_W(2)) b2 ();

    block_spawner #(.NUM_BLOCKS(4), .ADDR_W(8)) u_dut (
        .frame_clk (clk),
        .Reset     (rst_n),
        .bus       (b1)
    );

    block_spawner #(.NUM_BLOCKS(4), .ADDR_W(2)) u_dut2 (
        .frame_clk (clk),
        .Reset     (rst_n),
        .bus       (b2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) b1.pattern_data <= rom1[b1.pattern_addr];
    always @(posedge clk) b2.pattern_data <= rom2[b2.pattern_addr];

    task automatic check(input string tag, input logic [39:0] obs,
                         input logic [39:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] x_of(input logic [39:0] xc,
                                        input logic [3:0] m);
        logic [9:0] r;
        r = 10'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = xc[10*i +: 10];
        return r;
    endfunction

    // Every clear pulse must match the next queued spawn record.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_clear = 4'd0;
        end else begin
            if (prev_clear != 4'd0)
                check("rdy_after_clr", {36'd0, b1.block_ready & prev_clear},
                      {36'd0, prev_clear});
            if (b1.slot_clear != 4'd0) begin
                check("rdy_in_clr", {36'd0, b1.block_ready & b1.slot_clear}, 0);
                if (sb.size() == 0) begin
                    check("sb_unexpected", {36'd0, b1.slot_clear}, 0);
                end else begin
                    spawn_t e;
                    e = sb.pop_front();
                    check("sb_slot", {36'd0, b1.slot_clear}, {36'd0, e.mask});
                    check("sb_x", {30'd0, x_of(b1.block_x_center, b1.slot_clear)},
                          {30'd0, e.x});
                end
            end
            prev_clear = b1.slot_clear;
        end
    end

    task automatic push(input logic [3:0] m, input logic [9:0] x);
        spawn_t e;
        e.mask = m;
        e.x    = x;
        sb.push_back(e);
    endtask

    task automatic load(input logic [15:0] p [6]);
        for (int i = 0; i < 256; i++) rom1[i] = ENDE;
        for (int i = 0; i < 6; i++) rom1[i] = p[i];
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"}, {32'd0, b1.pattern_addr}, 0);
        check({tag, "_rdy"}, {36'd0, b1.block_ready}, 0);
        check({tag, "_clr"}, {36'd0, b1.slot_clear}, 0);
        check({tag, "_x"}, b1.block_x_center, X_RST);
        check({tag, "_done"}, {39'd0, b1.level_done}, 0);
        check({tag, "_cnt"}, {32'd0, b1.spawn_count}, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        b1.level_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        b1.level_start = 1'b0;
    endtask

    task automatic wait_clear(input string tag, input int budget);
        int k = 0;
        while (b1.slot_clear == 4'd0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {39'd0, b1.slot_clear != 4'd0}, 1);
    endtask

    task automatic wait_rdy(input string tag, input logic [3:0] exp,
                            input int budget);
        int k = 0;
        while (b1.block_ready !== exp && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {36'd0, b1.block_ready}, {36'd0, exp});
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (b1.level_done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {39'd0, b1.level_done}, 1);
    endtask

    task automatic release_all(input logic [3:0] m);
        @(negedge clk);
        b1.slot_end_level = m;
        @(negedge clk);
        b1.slot_end_level = 4'd0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        b1.level_start = 0; b1.slot_end_level = 0; b1.slot_hit = 0;
        b2.level_start = 0; b2.slot_end_level = 0; b2.slot_hit = 0;
        for (int i = 0; i < 256; i++) rom1[i] = ENDE;
        for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;
        rom2[1] = 16'h2000; rom2[2] = 16'h4000; rom2[3] = 16'h6000;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        // lane1 delay0, then END; end_level frees the slot
        load('{16'h2000, ENDE, ENDE, ENDE, ENDE, ENDE});
        push(4'b0001, 10'd280);
        pulse_start();
        wait_clear("t1_clr", 20);
        check("t1_lat", 40'(cyc - t0), 5);
        wait_rdy("t1_rdy", 4'b0001, 5);
        check("t1_cnt", {32'd0, b1.spawn_count}, 1);
        repeat (3) @(negedge clk);
        b1.slot_end_level = 4'b0001;
        @(negedge clk);
        b1.slot_end_level = 4'b0000;
        check("t1_rel", {36'd0, b1.block_ready}, 0);
        check("t1_done_lag", {39'd0, b1.level_done}, 0);
        @(negedge clk);
        check("t1_done", {39'd0, b1.level_done}, 1);
        check("t1_cnt_end", {32'd0, b1.spawn_count}, 1);

        // lane2 delay3: three extra wait frames
        load('{16'h4003, ENDE, ENDE, ENDE, ENDE, ENDE});
        push(4'b0001, 10'd400);
        pulse_start();
        wait_clear("t2_clr", 20);
        check("t2_lat", 40'(cyc - t0), 8);
        wait_rdy("t2_rdy", 4'b0001, 5);
        @(negedge clk);
        b1.slot_hit = 4'b0001;
        @(negedge clk);
        b1.slot_hit = 4'b0000;
        check("t2_hit", {36'd0, b1.block_ready}, 0);
        wait_done("t2_done", 10);
        check("t2_hold", {30'd0, b1.block_x_center[9:0]}, 400);

        // five entries: fill all slots, stall, hit on slot 2 refills it
        load('{16'h0000, 16'h2000, 16'h4000, 16'h6000, 16'h2000, ENDE});
        push(4'b0001, 10'd160);
        push(4'b0010, 10'd280);
        push(4'b0100, 10'd400);
        push(4'b1000, 10'd520);
        push(4'b0100, 10'd280);
        pulse_start();
        wait_rdy("t3_full", 4'b1111, 60);
        repeat (6) @(negedge clk);
        check("t3_stall_clr", {36'd0, b1.slot_clear}, 0);
        check("t3_stall_cnt", {32'd0, b1.spawn_count}, 4);
        check("t3_stall_addr", {32'd0, b1.pattern_addr}, 4);
        @(negedge clk);
        b1.slot_hit = 4'b0100;
        @(negedge clk);
        b1.slot_hit = 4'b0000;
        check("t3_freed", {36'd0, b1.block_ready}, {36'd0, 4'b1011});
        wait_rdy("t3_refill", 4'b1111, 10);
        check("t3_cnt", {32'd0, b1.spawn_count}, 5);
        repeat (3) @(negedge clk);
        release_all(4'b1111);
        wait_done("t3_done", 10);

        // release of slots 0,1 in the same frame as PLACE
        load('{16'h6000, 16'h0000, 16'h2000, 16'h4000, ENDE, ENDE});
        push(4'b0001, 10'd520);
        push(4'b0010, 10'd160);
        push(4'b0100, 10'd280);
        push(4'b0001, 10'd400);
        pulse_start();
        begin
            int k = 0;
            while (b1.slot_clear !== 4'b0010 && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("t4_second", {36'd0, b1.slot_clear}, {36'd0, 4'b0010});
        end
        repeat (4) @(negedge clk);
        b1.slot_end_level = 4'b0011;
        @(negedge clk);
        b1.slot_end_level = 4'b0000;
        check("t4_place", {36'd0, b1.slot_clear}, {36'd0, 4'b0100});
        check("t4_rdy", {36'd0, b1.block_ready}, 0);
        wait_rdy("t4_last", 4'b0101, 20);
        check("t4_cnt", {32'd0, b1.spawn_count}, 4);
        repeat (3) @(negedge clk);
        release_all(4'b0101);
        wait_done("t4_done", 10);

        // asynchronous reset during a long WAIT with two busy slots
        load('{16'h2000, 16'h4000, 16'h60C8, ENDE, ENDE, ENDE});
        push(4'b0001, 10'd280);
        push(4'b0010, 10'd400);
        pulse_start();
        wait_rdy("t5_two", 4'b0011, 40);
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("t5_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        load('{16'h4000, ENDE, ENDE, ENDE, ENDE, ENDE});
        push(4'b0001, 10'd400);
        pulse_start();
        wait_clear("t5_clr", 20);
        check("t5_lat", 40'(cyc - t0), 5);
        wait_rdy("t5_rdy", 4'b0001, 5);
        check("t5_addr", {32'd0, b1.pattern_addr}, 1);
        check("t5_cnt", {32'd0, b1.spawn_count}, 1);
        repeat (3) @(negedge clk);
        release_all(4'b0001);
        wait_done("t5_done", 10);

        // ADDR_W=2 with no END: stops at the last address
        @(negedge clk);
        b2.level_start = 1'b1;
        @(negedge clk);
        b2.level_start = 1'b0;
        begin
            int k = 0;
            while (b2.block_ready !== 4'b1111 && k < 60) begin
                @(negedge clk);
                k++;
            end
            check("t6_full", {36'd0, b2.block_ready}, {36'd0, 4'b1111});
        end
        check("t6_x", b2.block_x_center,
              {10'd520, 10'd400, 10'd280, 10'd160});
        check("t6_cnt", {32'd0, b2.spawn_count}, 4);
        repeat (8) @(negedge clk);
        check("t6_addr", {38'd0, b2.pattern_addr}, 3);
        check("t6_noclr", {36'd0, b2.slot_clear}, 0);
        b2.slot_end_level = 4'b1111;
        @(negedge clk);
        b2.slot_end_level = 4'b0000;
        begin
            int k = 0;
            while (b2.level_done !== 1'b1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("t6_done", {39'd0, b2.level_done}, 1);
        end
        check("t6_addr_end", {38'd0, b2.pattern_addr}, 3);
        check("t6_cnt_end", {32'd0, b2.spawn_count}, 4);

        check("sb_left", 40'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/block_spawner.md
Name: block_spawner

Overview:
- Level sequencer directly upstream of the falling-block movers.
- Walks a pattern ROM of spawn entries, waits the programmed frame gap, then claims a free mover slot.
- For each claimed slot it loads the lane X centre, pulses that slot's clear (wired into the mover's Collision input at top level) and asserts block_ready.
- Frees slots when a mover reports end_level or a hit, and flags level completion once the pattern ends and every slot is idle.

Parameters:
- NUM_BLOCKS, 4, number of mover slots driven.
- ADDR_W, 8, pattern ROM address width.
- LANE0_X, 160, X centre for lane 0.
- LANE1_X, 280, X centre for lane 1.
- LANE2_X, 400, X centre for lane 2.
- LANE3_X, 520, X centre for lane 3.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- level_start  in  1  one-frame start pulse.
- pattern_data  in  16  ROM entry: [15] END, [14:13] lane, [12:8] reserved (zero), [7:0] delay frames.
- pattern_addr  out  ADDR_W  ROM address; the ROM is registered with 1-frame read latency.
- slot_end_level  in  NUM_BLOCKS  end_level from each mover.
- slot_hit  in  NUM_BLOCKS  collision/hit per slot.
- block_ready  out  NUM_BLOCKS  per-slot motion enable.
- slot_clear  out  NUM_BLOCKS  one-frame pulse; resets mover position to Y=0.
- block_x_center  out  10*NUM_BLOCKS  packed X centres; slot i occupies [10i+9:10i].
- level_done  out  1  pattern finished and all slots idle.
- spawn_count  out  8  blocks spawned this level, saturating at 255.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, pattern_addr=0, busy=0, block_ready=0, slot_clear=0, every block_x_center field=LANE0_X, level_done=0, spawn_count=0, delay counter=0.
- All outputs are registered.
- FSM states: IDLE, FETCH, DECODE, WAIT, PLACE, ARM, DRAIN, DONE.
- IDLE/DONE + level_start=1:
  - pattern_addr<=0, spawn_count<=0, level_done<=0, go to FETCH.
  - level_start is ignored in every other state.
- FETCH: waits one frame for ROM data, then goes to DECODE.
- DECODE:
  - If END=1, go to DRAIN.
  - Otherwise latch lane, counter<=delay, go to WAIT.
- WAIT:
  - counter==0: go to PLACE.
  - Otherwise decrement the counter.
  - DECODE-to-PLACE therefore takes delay+1 frames.
- PLACE:
  - Evaluated against busy as registered before the edge.
  - If no slot is free, stay in PLACE (stall) with no outputs changed.
  - Otherwise pick the lowest free index i: x_center[i]<=lane X, slot_clear[i]<=1, busy[i]<=1, go to ARM.
- ARM:
  - slot_clear<=0, block_ready[i]<=1, spawn_count increments (saturating).
  - If pattern_addr is at its maximum (all ones), go to DRAIN (implicit END).
  - Otherwise pattern_addr increments, go to FETCH.
- Ordering guarantee: x_center[i] is stable in the frame when slot_clear[i] is high, and block_ready[i] rises exactly one frame after slot_clear[i].
- Minimum entry-to-entry period is delay+5 frames.
- Slot release, in any state:
  - If busy[i] and block_ready[i] and (slot_end_level[i] or slot_hit[i]), then busy[i]<=0 and block_ready[i]<=0 on the next edge.
  - Release events on non-busy slots are ignored.
  - During the clear frame block_ready[i]=0, so a stale end_level on that slot cannot free it.
  - A release and a PLACE in the same frame cannot target the same slot; the freed slot becomes eligible the frame after.
- DRAIN: when busy==0, set level_done<=1 and go to DONE.
- DONE: level_done holds at 1 until level_start or reset.
- Lane-to-X mapping: lane 0..3 maps to LANE0_X..LANE3_X; all arithmetic is unsigned 10-bit.
- Reset mid-operation returns every slot to idle immediately.
- x_center fields hold their last value while a slot is idle.

Test Plan:
- Reset deassert, ROM {lane1 delay0, END}, level_start: slot_clear=0001 with x_center[0]=280, block_ready=0001 the next frame; pulse slot_end_level[0] → block_ready=0000, level_done=1 one frame after busy clears; spawn_count=1.
- Entry {lane2, delay 3}: PLACE occurs exactly 4 frames after DECODE, and slot_clear rises the frame after that.
- 5 non-END entries with delay 0 and no releases: slots 0–3 fill, FSM stalls in PLACE; slot_hit[2] → next spawn takes slot 2 with the 5th lane X.
- Simultaneous slot_end_level=0011 while PLACE would pick a slot: both slots are freed, the placement targets the lowest free slot per the pre-edge busy value, and no slot is double-claimed.
- Reset low while in WAIT with 2 busy slots: all outputs return to their reset values asynchronously; level_start after reset restarts from pattern_addr=0.
- ROM with no END and ADDR_W=2: after 4 spawns the FSM enters DRAIN without wrapping the address.
